// File: rtl/fetch_redirect_if.sv
// Fetch/decode handshake bundle between program_memory_block and fetch_redirect_ctrl.
// The master side (fetch) drives the instruction stream; the slave side returns fetch control.
interface fetch_redirect_if;
   logic [31:0] ins;
   logic [15:0] current_address;
   logic        cmp_zero;
   logic [15:0] jmp_loc;
   logic        pc_mux_sel;
   logic        stall;
   logic        stall_pm;
   logic [31:0] ins_dec;
   logic [15:0] pc_dec;

   modport master (
      output ins, current_address, cmp_zero,
      input  jmp_loc, pc_mux_sel, stall, stall_pm, ins_dec, pc_dec
   );

   modport slave (
      input  ins, current_address, cmp_zero,
      output jmp_loc, pc_mux_sel, stall, stall_pm, ins_dec, pc_dec
   );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Decode-stage register plus fetch control: jump/branch redirect, wrong-path flush
// and single-cycle load-use hold. Every output comes straight from a register.
module fetch_redirect_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
   input logic            clk,
   input logic            reset,
   fetch_redirect_if.slave bus
);
   localparam logic [5:0] OP_JMP  = 6'b000010;
   localparam logic [5:0] OP_BEQZ = 6'b000100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {S_RUN, S_HOLD, S_REDIRECT, S_FLUSH} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] jmp_loc_q, jmp_loc_d;
   logic        pc_mux_sel_q, pc_mux_sel_d;
   logic        stall_q, stall_d;
   logic [31:0] ins_dec_q, ins_dec_d;
   logic [15:0] pc_dec_q, pc_dec_d;

   // Fetched-instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic [15:0] imm;
   assign opcode = bus.ins[31:26];
   assign rs     = bus.ins[25:21];
   assign rt     = bus.ins[20:16];
   assign imm    = bus.ins[15:0];

   // Load sitting in decode and the register it writes
   logic       dec_is_lw;
   logic [4:0] dec_rt;
   assign dec_is_lw = (ins_dec_q[31:26] == OP_LW);
   assign dec_rt    = ins_dec_q[20:16];

   // Either source field of the fetched instruction may read the load destination
   logic [4:0] src_field [2];
   logic [1:0] src_match;
   assign src_field[0] = rs;
   assign src_field[1] = rt;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src_match
         assign src_match[gi] = (src_field[gi] == dec_rt);
      end
   endgenerate

   logic        hazard;
   logic        is_jmp, taken;
   logic [15:0] target;
   logic        eval_en, hazard_en;

   assign hazard  = dec_is_lw && (dec_rt != 5'd0) && (|src_match);
   assign is_jmp  = (opcode == OP_JMP);
   assign taken   = is_jmp || ((opcode == OP_BEQZ) && bus.cmp_zero);
   assign target  = is_jmp ? imm : (bus.current_address + 16'd1 + imm);
   assign eval_en = (state_q == S_RUN) || (state_q == S_HOLD);
   // HOLD re-evaluates the held instruction with the hazard already resolved
   assign hazard_en = (state_q == S_RUN) && hazard;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_RUN;
         cnt_q        <= 2'd0;
         jmp_loc_q    <= 16'd0;
         pc_mux_sel_q <= 1'b0;
         stall_q      <= 1'b0;
         ins_dec_q    <= NOP_WORD;
         pc_dec_q     <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         jmp_loc_q    <= jmp_loc_d;
         pc_mux_sel_q <= pc_mux_sel_d;
         stall_q      <= stall_d;
         ins_dec_q    <= ins_dec_d;
         pc_dec_q     <= pc_dec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN, S_HOLD: begin
            if (hazard_en)  state_d = S_HOLD;
            else if (taken) state_d = S_REDIRECT;
            else            state_d = S_RUN;
         end
         S_REDIRECT: state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
         S_FLUSH:    state_d = (cnt_q <= 2'd1) ? S_RUN : S_FLUSH;
         default:    state_d = S_RUN;
      endcase
   end

   always_comb begin
      cnt_d        = cnt_q;
      jmp_loc_d    = jmp_loc_q;
      pc_mux_sel_d = 1'b0;
      stall_d      = 1'b0;
      ins_dec_d    = ins_dec_q;
      pc_dec_d     = pc_dec_q;
      if (eval_en) begin
         if (hazard_en) begin
            stall_d   = 1'b1;
            ins_dec_d = NOP_WORD;
         end else begin
            ins_dec_d = bus.ins;
            pc_dec_d  = bus.current_address;
            if (taken) begin
               jmp_loc_d    = target;
               pc_mux_sel_d = 1'b1;
            end
         end
      end else if (state_q == S_REDIRECT) begin
         cnt_d     = FLUSH_INIT;
         ins_dec_d = NOP_WORD;
      end else begin
         // Wrong-path slot: whatever arrives on ins is discarded
         ins_dec_d = NOP_WORD;
         if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
      end
   end

   assign bus.jmp_loc    = jmp_loc_q;
   assign bus.pc_mux_sel = pc_mux_sel_q;
   assign bus.stall      = stall_q;
   assign bus.stall_pm   = stall_q;
   assign bus.ins_dec    = ins_dec_q;
   assign bus.pc_dec     = pc_dec_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scenarios from the block's test plan plus a randomized instruction stream
// checked against a cycle-level reference model of the decode/redirect rules.
module tb_fetch_redirect_ctrl;
   localparam int          FC  = 2;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_redirect_if bus ();

   fetch_redirect_ctrl #(.FLUSH_CYCLES(FC), .NOP_WORD(NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] ins;
      logic [15:0] addr;
      logic        cz;
      logic        rst;
      logic [15:0] e_jmp;
      logic        e_sel;
      logic        e_stall;
      logic [31:0] e_ins;
      logic [15:0] e_pc;
   } step_t;

   // Reference model: post-edge view of the decode stage
   logic [31:0] m_ins_dec = NOP;
   logic [15:0] m_pc_dec = 16'd0;
   logic [15:0] m_jmp = 16'd0;
   logic        m_sel = 1'b0;
   logic        m_stall = 1'b0;
   int          m_nops = 0;

   task automatic model_step();
      logic [4:0] lw_rt;
      logic       hz;
      if (reset) begin
         m_ins_dec = NOP; m_pc_dec = 16'd0; m_jmp = 16'd0;
         m_sel = 1'b0; m_stall = 1'b0; m_nops = 0;
      end else if (m_sel) begin
         m_sel = 1'b0; m_stall = 1'b0; m_ins_dec = NOP; m_nops = FC - 1;
      end else if (m_nops > 0) begin
         m_stall = 1'b0; m_ins_dec = NOP; m_nops = m_nops - 1;
      end else begin
         lw_rt = m_ins_dec[20:16];
         hz = !m_stall && (m_ins_dec[31:26] == 6'b100011) && (lw_rt != 5'd0) &&
              ((bus.ins[25:21] == lw_rt) || (bus.ins[20:16] == lw_rt));
         if (hz) begin
            m_stall = 1'b1; m_ins_dec = NOP;
         end else begin
            m_stall = 1'b0; m_ins_dec = bus.ins; m_pc_dec = bus.current_address;
            if (bus.ins[31:26] == 6'b000010) begin
               m_sel = 1'b1; m_jmp = bus.ins[15:0];
            end else if (bus.ins[31:26] == 6'b000100 && bus.cmp_zero) begin
               m_sel = 1'b1; m_jmp = 16'(bus.current_address + 16'd1 + bus.ins[15:0]);
            end
         end
      end
   endtask

   task automatic tick(input logic [31:0] i, input logic [15:0] a, input logic cz, input logic r);
      bus.ins = i; bus.current_address = a; bus.cmp_zero = cz; reset = r;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t s[$];
      s.push_back('{32'h0800_0008, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,          16'h0000});
      s.push_back('{32'h0800_0008, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,          16'h0000});
      s.push_back('{32'h0800_0008, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b0, 32'h0800_0008, 16'h0000});
      s.push_back('{32'h0022_1000, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, NOP,          16'h0000});
      s.push_back('{32'h0022_1001, 16'h0002, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, NOP,          16'h0000});
      s.push_back('{32'h0022_1008, 16'h0008, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 32'h0022_1008, 16'h0008});
      foreach (s[k]) begin
         tick(s[k].ins, s[k].addr, s[k].cz, s[k].rst);
         checks++;
         $display("reset step %0d: ins_dec=%h pc_dec=%h sel=%b jmp=%h", k, bus.ins_dec, bus.pc_dec, bus.pc_mux_sel, bus.jmp_loc);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_stall, s[k].e_ins, s[k].e_pc}) begin
            failures++;
            $display("FAIL reset step %0d got jmp=%h sel=%b st=%b/%b ins=%h pc=%h exp jmp=%h sel=%b st=%b ins=%h pc=%h",
                     k, bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec,
                     s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_ins, s[k].e_pc);
         end
      end
   endtask

   task automatic test_sequential();
      step_t s[$];
      s.push_back('{NOP, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP, 16'h0000});
      for (int a = 0; a < 4; a++)
         s.push_back('{32'h0022_1000 + 32'(a), 16'(a), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0,
                       32'h0022_1000 + 32'(a), 16'(a)});
      foreach (s[k]) begin
         tick(s[k].ins, s[k].addr, s[k].cz, s[k].rst);
         checks++;
         $display("sequential step %0d: ins_dec=%h pc_dec=%h", k, bus.ins_dec, bus.pc_dec);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_stall, s[k].e_ins, s[k].e_pc}) begin
            failures++;
            $display("FAIL sequential step %0d got sel=%b st=%b/%b ins=%h pc=%h exp ins=%h pc=%h",
                     k, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec, s[k].e_ins, s[k].e_pc);
         end
      end
   endtask

   task automatic test_jmp_flush();
      step_t s[$];
      s.push_back('{NOP,           16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,           16'h0000});
      s.push_back('{32'h0022_1004, 16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0022_1004, 16'h0004});
      s.push_back('{32'h0800_0040, 16'h0005, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 32'h0800_0040, 16'h0005});
      s.push_back('{32'h0800_0080, 16'h0006, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, NOP,           16'h0005});
      s.push_back('{32'h1060_0010, 16'h0007, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, NOP,           16'h0005});
      s.push_back('{32'h0022_1040, 16'h0040, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 32'h0022_1040, 16'h0040});
      s.push_back('{32'h0022_1041, 16'h0041, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 32'h0022_1041, 16'h0041});
      foreach (s[k]) begin
         tick(s[k].ins, s[k].addr, s[k].cz, s[k].rst);
         checks++;
         $display("jmp_flush step %0d: ins_dec=%h pc_dec=%h sel=%b jmp=%h", k, bus.ins_dec, bus.pc_dec, bus.pc_mux_sel, bus.jmp_loc);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_stall, s[k].e_ins, s[k].e_pc}) begin
            failures++;
            $display("FAIL jmp_flush step %0d got jmp=%h sel=%b st=%b/%b ins=%h pc=%h exp jmp=%h sel=%b ins=%h pc=%h",
                     k, bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec,
                     s[k].e_jmp, s[k].e_sel, s[k].e_ins, s[k].e_pc);
         end
      end
   endtask

   task automatic test_beqz_wrap();
      step_t s[$];
      s.push_back('{NOP,           16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,           16'h0000});
      s.push_back('{32'h1060_0003, 16'hFFFE, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 32'h1060_0003, 16'hFFFE});
      s.push_back('{32'h0022_1000, 16'hFFFF, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, NOP,           16'hFFFE});
      s.push_back('{32'h0022_1001, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, NOP,           16'hFFFE});
      s.push_back('{32'h1060_0003, 16'hFFFE, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 32'h1060_0003, 16'hFFFE});
      s.push_back('{32'h0022_1002, 16'hFFFF, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 32'h0022_1002, 16'hFFFF});
      foreach (s[k]) begin
         tick(s[k].ins, s[k].addr, s[k].cz, s[k].rst);
         checks++;
         $display("beqz_wrap step %0d: ins_dec=%h pc_dec=%h sel=%b jmp=%h", k, bus.ins_dec, bus.pc_dec, bus.pc_mux_sel, bus.jmp_loc);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_stall, s[k].e_ins, s[k].e_pc}) begin
            failures++;
            $display("FAIL beqz_wrap step %0d got jmp=%h sel=%b st=%b/%b ins=%h pc=%h exp jmp=%h sel=%b ins=%h pc=%h",
                     k, bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec,
                     s[k].e_jmp, s[k].e_sel, s[k].e_ins, s[k].e_pc);
         end
      end
   endtask

   task automatic test_load_use();
      step_t s[$];
      s.push_back('{NOP,           16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,           16'h0000});
      // rs of the next instruction reads the load destination
      s.push_back('{32'h8C25_0004, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h8C25_0004, 16'h0010});
      s.push_back('{32'h00A2_0007, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, NOP,           16'h0010});
      s.push_back('{32'h00A2_0007, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h00A2_0007, 16'h0011});
      s.push_back('{32'h0022_1012, 16'h0012, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0022_1012, 16'h0012});
      // load into r0 never stalls
      s.push_back('{32'h8C20_0004, 16'h0013, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h8C20_0004, 16'h0013});
      s.push_back('{32'h0002_0007, 16'h0014, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0002_0007, 16'h0014});
      // rt of the next instruction reads the load destination
      s.push_back('{32'h8C25_0004, 16'h0015, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h8C25_0004, 16'h0015});
      s.push_back('{32'h0025_0009, 16'h0016, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, NOP,           16'h0015});
      s.push_back('{32'h0025_0009, 16'h0016, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0025_0009, 16'h0016});
      // hazard and taken branch together: hold first, then redirect
      s.push_back('{32'h8C25_0004, 16'h0017, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h8C25_0004, 16'h0017});
      s.push_back('{32'h10A0_0020, 16'h0018, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, NOP,           16'h0017});
      s.push_back('{32'h10A0_0020, 16'h0018, 1'b1, 1'b0, 16'h0039, 1'b1, 1'b0, 32'h10A0_0020, 16'h0018});
      foreach (s[k]) begin
         tick(s[k].ins, s[k].addr, s[k].cz, s[k].rst);
         checks++;
         $display("load_use step %0d: ins_dec=%h pc_dec=%h stall=%b sel=%b", k, bus.ins_dec, bus.pc_dec, bus.stall, bus.pc_mux_sel);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_stall, s[k].e_ins, s[k].e_pc}) begin
            failures++;
            $display("FAIL load_use step %0d got jmp=%h sel=%b st=%b/%b ins=%h pc=%h exp jmp=%h sel=%b st=%b ins=%h pc=%h",
                     k, bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec,
                     s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_ins, s[k].e_pc);
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      step_t s[$];
      s.push_back('{NOP,           16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,           16'h0000});
      s.push_back('{32'h0800_0030, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b1, 1'b0, 32'h0800_0030, 16'h0020});
      s.push_back('{32'h0022_1021, 16'h0021, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, NOP,           16'h0020});
      s.push_back('{32'h0022_1022, 16'h0022, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, NOP,           16'h0000});
      s.push_back('{32'h0022_1005, 16'h0050, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0022_1005, 16'h0050});
      s.push_back('{32'h0022_1006, 16'h0051, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0022_1006, 16'h0051});
      foreach (s[k]) begin
         tick(s[k].ins, s[k].addr, s[k].cz, s[k].rst);
         checks++;
         $display("reset_mid_flush step %0d: ins_dec=%h pc_dec=%h sel=%b", k, bus.ins_dec, bus.pc_dec, bus.pc_mux_sel);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {s[k].e_jmp, s[k].e_sel, s[k].e_stall, s[k].e_stall, s[k].e_ins, s[k].e_pc}) begin
            failures++;
            $display("FAIL reset_mid_flush step %0d got jmp=%h sel=%b st=%b/%b ins=%h pc=%h exp jmp=%h sel=%b ins=%h pc=%h",
                     k, bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec,
                     s[k].e_jmp, s[k].e_sel, s[k].e_ins, s[k].e_pc);
         end
      end
   endtask

   // Random program; the fetch environment follows the model's stall/redirect decisions
   task automatic test_random();
      logic [31:0] mem [256];
      logic [15:0] fa = 16'h0000;
      logic [15:0] tgt = 16'h0000;
      logic        pend = 1'b0;
      logic        r;
      int          sel;
      for (int i = 0; i < 256; i++) begin
         sel = int'($urandom_range(0, 99));
         mem[i] = {(sel < 12) ? 6'b000010 : (sel < 26) ? 6'b000100 : (sel < 50) ? 6'b100011 : 6'b000000,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      end
      tick(NOP, 16'h0000, 1'b0, 1'b1);
      for (int c = 0; c < 600; c++) begin
         r = ($urandom_range(0, 79) == 0);
         tick(mem[fa[7:0]], fa, 1'($urandom_range(0, 1)), r);
         checks++;
         $display("random %0d: addr=%h ins=%h -> ins_dec=%h pc_dec=%h sel=%b stall=%b", c, fa, mem[fa[7:0]],
                  bus.ins_dec, bus.pc_dec, bus.pc_mux_sel, bus.stall);
         if ({bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec} !==
             {m_jmp, m_sel, m_stall, m_stall, m_ins_dec, m_pc_dec}) begin
            failures++;
            $display("FAIL random cycle %0d got jmp=%h sel=%b st=%b/%b ins=%h pc=%h exp jmp=%h sel=%b st=%b ins=%h pc=%h",
                     c, bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.ins_dec, bus.pc_dec,
                     m_jmp, m_sel, m_stall, m_ins_dec, m_pc_dec);
         end
         if (r) begin
            fa = 16'($urandom_range(0, 255)); pend = 1'b0;
         end else if (m_stall) begin
            fa = fa;
         end else if (m_sel) begin
            pend = 1'b1; tgt = m_jmp; fa = fa + 16'd1;
         end else if (pend && m_nops == 0) begin
            fa = tgt; pend = 1'b0;
         end else begin
            fa = fa + 16'd1;
         end
      end
   endtask

   initial begin
      bus.ins = NOP;
      bus.current_address = 16'h0000;
      bus.cmp_zero = 1'b0;
      #2;
      test_reset();
      test_sequential();
      test_jmp_flush();
      test_beqz_wrap();
      test_load_use();
      test_reset_mid_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
